// File: rtl/mod_pkg.sv
// Shared types and PRBS7 helpers for the symbol-rate modulator.
// Covers the modulation modes, the FSM states and the x^7+x^6+1 feedback.
package mod_pkg;

    typedef enum logic [1:0] {MOD_ASK, MOD_FSK, MOD_BPSK, MOD_PASS} mod_e;
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} st_e;

    localparam int PRBS_LEN   = 7;
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    function automatic logic [PRBS_LEN-1:0] prbs7_next(input logic [PRBS_LEN-1:0] s);
        return {s[PRBS_LEN-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with a rising-edge detector for a divided clock used as data.
// Usable by any consumer of the symbol-rate divider.
module sync_rise (
    input  logic inclk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic s1, s2, s3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/prbs_modulator.sv
// Preamble + PRBS7 bit source keying ASK/FSK/BPSK between two carrier sample streams.
// Define PRBS_DIFF_EN to differentially encode the DATA bits.
module prbs_modulator
    import mod_pkg::*;
#(
    parameter int         SAMPLE_W = 12,
    parameter int         PRE_LEN  = 8,
    parameter logic [6:0] SEED     = 7'h7F
) (
    input  logic                       inclk,
    input  logic                       reset_n,
    input  logic                       symclk,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic signed [SAMPLE_W-1:0] carrier_a,
    input  logic signed [SAMPLE_W-1:0] carrier_b,
    output logic                       data_bit,
    output logic                       bit_strobe,
    output logic                       in_data,
    output logic signed [SAMPLE_W-1:0] mod_out
);

    localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [SAMPLE_W-1:0] S_MAX = ~S_MIN;

    logic                       rise;
    st_e                        state;
    mod_e                       mode_q;
    logic [PRBS_LEN-1:0]        lfsr;
    logic [PRBS_LEN-1:0]        lfsr_eff;
    logic [7:0]                 pre_cnt;
    logic signed [SAMPLE_W-1:0] neg_a;
    logic signed [SAMPLE_W-1:0] mod_sel;

    sync_rise u_sync (
        .inclk   (inclk),
        .reset_n (reset_n),
        .d       (symclk),
        .rise    (rise)
    );

    // An all-zero register would lock up; fall back to SEED if it ever appears.
    assign lfsr_eff = (lfsr == '0) ? SEED : lfsr;

    // BPSK inversion saturates so the most negative sample maps to full scale.
    assign neg_a = (carrier_a == S_MIN) ? S_MAX : -carrier_a;

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        mod_sel = carrier_a;
        case (mode_q)
            MOD_ASK:  mod_sel = data_bit ? carrier_a : '0;
            MOD_FSK:  mod_sel = data_bit ? carrier_b : carrier_a;
            MOD_BPSK: mod_sel = data_bit ? carrier_a : neg_a;
            default:  mod_sel = carrier_a;
        endcase
    end

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mode_q     <= MOD_ASK;
            lfsr       <= SEED;
            pre_cnt    <= '0;
            data_bit   <= 1'b0;
            bit_strobe <= 1'b0;
            in_data    <= 1'b0;
            mod_out    <= '0;
        end else begin
            bit_strobe <= 1'b0;
            if (!en) begin
                state    <= ST_IDLE;
                lfsr     <= SEED;
                pre_cnt  <= '0;
                data_bit <= 1'b0;
                in_data  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_PRE;
                        pre_cnt <= '0;
                        mode_q  <= mod_e'(mode);
                    end
                    ST_PRE: if (rise) begin
                        data_bit   <= ~pre_cnt[0];
                        pre_cnt    <= pre_cnt + 8'd1;
                        bit_strobe <= 1'b1;
                        mode_q     <= mod_e'(mode);
                        if (pre_cnt == PRE_LAST) begin
                            state   <= ST_DATA;
                            in_data <= 1'b1;
                        end
                    end
                    ST_DATA: if (rise) begin
`ifdef PRBS_DIFF_EN
                        data_bit <= data_bit ^ lfsr_eff[PRBS_TAP_A];
`else
                        data_bit <= lfsr_eff[PRBS_TAP_A];
`endif
                        lfsr       <= prbs7_next(lfsr_eff);
                        bit_strobe <= 1'b1;
                        mode_q     <= mod_e'(mode);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
            mod_out <= (state == ST_IDLE) ? '0 : mod_sel;
        end
    end

endmodule

// File: tb/tb_prbs_modulator.sv
// Self-checking bench for prbs_modulator: preamble, PRBS7 sequence, modulation mapping,
// en/reset behaviour. Honours PRBS_DIFF_EN when defined.
module tb_prbs_modulator;

    localparam int         SAMPLE_W = 12;
    localparam int         PRE_LEN  = 8;
    localparam logic [6:0] SEED     = 7'h7F;
    localparam int         SYM_PER  = 20;

    logic                       inclk = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       symclk = 1'b0;
    logic                       en = 1'b0;
    logic [1:0]                 mode = 2'd0;
    logic signed [SAMPLE_W-1:0] carrier_a = '0;
    logic signed [SAMPLE_W-1:0] carrier_b = '0;
    logic                       data_bit;
    logic                       bit_strobe;
    logic                       in_data;
    logic signed [SAMPLE_W-1:0] mod_out;

    int   errors = 0;
    int   checks = 0;
    bit   prbs[$];
    logic cur_bit = 1'b0;

    always #5 inclk = ~inclk;

    prbs_modulator #(
        .SAMPLE_W (SAMPLE_W),
        .PRE_LEN  (PRE_LEN),
        .SEED     (SEED)
    ) dut (
        .inclk      (inclk),
        .reset_n    (reset_n),
        .symclk     (symclk),
        .en         (en),
        .mode       (mode),
        .carrier_a  (carrier_a),
        .carrier_b  (carrier_b),
        .data_bit   (data_bit),
        .bit_strobe (bit_strobe),
        .in_data    (in_data),
        .mod_out    (mod_out)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference mapping written directly from the modulation rules with integer arithmetic.
    function automatic int exp_mod(input int m, input logic b, input int a, input int bc);
        int maxv;
        maxv = (1 << (SAMPLE_W - 1)) - 1;
        case (m)
            0:       return b ? a : 0;
            1:       return b ? bc : a;
            2:       return b ? a : ((-a > maxv) ? maxv : -a);
            default: return a;
        endcase
    endfunction

    function automatic int rand_sample();
        if ($urandom_range(0, 3) == 0) return -(1 << (SAMPLE_W - 1));
        return int'($urandom_range(0, (1 << SAMPLE_W) - 1)) - (1 << (SAMPLE_W - 1));
    endfunction

    // One symbol period starting just after a posedge: rise, then SYM_PER edges.
    // The bit must update on the 3rd edge; the mode input is scrambled mid-bit.
    task automatic symbol(input string tag, input logic exp_strobe, input logic exp_bit,
                          input logic exp_in, input logic idle,
                          input int m, input int a, input int bc);
        mode      = m[1:0];
        carrier_a = a[SAMPLE_W-1:0];
        carrier_b = bc[SAMPLE_W-1:0];
        symclk    = 1'b1;
        for (int i = 1; i <= SYM_PER; i++) begin
            @(posedge inclk);
            #1;
            if (i == 3) begin
                check({tag, " strobe"}, 32'(bit_strobe), 32'(exp_strobe));
                if (exp_strobe) begin
                    check({tag, " bit"}, 32'(data_bit), 32'(exp_bit));
                    cur_bit = exp_bit;
                end
            end else begin
                check({tag, " quiet"}, 32'(bit_strobe), 0);
            end
            if (i == SYM_PER) begin
                check({tag, " in_data"}, 32'(in_data), 32'(exp_in));
                check({tag, " mod_out"}, 32'(mod_out),
                      idle ? 0 : exp_mod(m, cur_bit, a, bc));
            end
            if (i == 5) mode = mode ^ 2'($urandom_range(1, 3));
            if (i == SYM_PER / 2) symclk = 1'b0;
        end
    endtask

    // Full preamble followed by n_data DATA bits, PRBS restarting from SEED.
    task automatic run_frame(input string tag, input int n_data);
        int   m, a, bc;
        logic b;
        for (int p = 0; p < PRE_LEN; p++) begin
            m  = int'($urandom_range(0, 3));
            a  = rand_sample();
            bc = rand_sample();
            symbol($sformatf("%s pre%0d", tag, p), 1'b1, (p % 2 == 0), (p == PRE_LEN - 1), 1'b0, m, a, bc);
        end
        for (int d = 0; d < n_data; d++) begin
            m  = int'($urandom_range(0, 3));
            a  = rand_sample();
            bc = rand_sample();
            if (d == 7) begin m = 2; a = -(1 << (SAMPLE_W - 1)); end
            if (d == 8) m = 0;
            if (d == 9) m = 1;
`ifdef PRBS_DIFF_EN
            b = cur_bit ^ prbs[d];
`else
            b = prbs[d];
`endif
            symbol($sformatf("%s data%0d", tag, d), 1'b1, b, 1'b1, 1'b0, m, a, bc);
        end
    endtask

    initial begin
        logic [6:0] seed_v;
        seed_v = SEED;
        // PRBS7 output sequence: first 7 bits are the seed MSB-first, then o[n+7] = o[n] ^ o[n+1].
        for (int n = 0; n < 7; n++) prbs.push_back(seed_v[6 - n]);
        for (int n = 0; n < 300; n++) prbs.push_back(prbs[n] ^ prbs[n + 1]);

        repeat (3) @(posedge inclk);
        #1;
        check("reset data_bit", 32'(data_bit), 0);
        check("reset strobe", 32'(bit_strobe), 0);
        check("reset in_data", 32'(in_data), 0);
        check("reset mod_out", 32'(mod_out), 0);
        reset_n = 1'b1;

        symbol("idle", 1'b0, 1'b0, 1'b0, 1'b1, 3, 100, 200);
        en = 1'b1;
        @(posedge inclk);
        #1;
        run_frame("run1", 254);

        // en dropped in the cycle the rise is detected: no strobe, back to IDLE.
        symclk = 1'b1;
        for (int i = 1; i <= SYM_PER; i++) begin
            @(posedge inclk);
            #1;
            if (i == 3) begin
                check("en_drop strobe", 32'(bit_strobe), 0);
                check("en_drop data_bit", 32'(data_bit), 0);
                check("en_drop in_data", 32'(in_data), 0);
            end
            if (i == 4) check("en_drop mod_out", 32'(mod_out), 0);
            if (i == 2) en = 1'b0;
            if (i == SYM_PER / 2) symclk = 1'b0;
        end
        cur_bit = 1'b0;
        en = 1'b1;
        @(posedge inclk);
        #1;
        run_frame("run2", 20);

        // Asynchronous reset in the middle of DATA.
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset data_bit", 32'(data_bit), 0);
        check("midreset strobe", 32'(bit_strobe), 0);
        check("midreset in_data", 32'(in_data), 0);
        check("midreset mod_out", 32'(mod_out), 0);
        en = 1'b0;
        @(posedge inclk);
        #1;
        reset_n = 1'b1;
        cur_bit = 1'b0;
        symbol("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, 2, -5, 7);
        en = 1'b1;
        @(posedge inclk);
        #1;
        run_frame("run3", 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
